instr_fetch: RTL

//  Fetch stage directly upstream of control_unit. Owns the program counter, reads 16-bit

---
 rtl/instr_fetch_pkg.sv | 28 ++
 rtl/instr_fetch_skid_buf.sv | 50 +++++
 rtl/instr_fetch.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_pkg.sv
// ----------------------------------------------------------------------------
// instr_fetch_pkg
//   Shared definitions for the fetch stage and its consumers: default
//   address/data widths, the reset PC, the fetch FSM state encoding and the
//   bit that distinguishes instruction types for control_unit.
// ----------------------------------------------------------------------------
package instr_fetch_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;

  localparam logic [ADDR_W_DEF-1:0] RESET_PC_DEF = 16'h0000;

  // Bit 15 of an instruction word selects the instruction type.
  localparam int INSTR_TYPE_BIT = 15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } fetch_state_e;

  function automatic logic instr_type(input logic [DATA_W_DEF-1:0] word);
    return word[INSTR_TYPE_BIT];
  endfunction

endpackage

// File: rtl/instr_fetch_skid_buf.sv
// ----------------------------------------------------------------------------
// instr_fetch_skid_buf
//   One-entry holding register for an instruction word and its address.
//   Catches a memory response that arrives while the output slot is still
//   occupied, so the in-flight read is never lost.
// Ports
//   clk, rst     clock, asynchronous active-high reset
//   load         capture data_in/pc_in and mark full
//   unload       mark empty (contents handed to the output slot)
//   flush        mark empty (redirect); wins over load/unload
//   data_in      instruction word to capture
//   pc_in        address of that word
//   data, pc     held entry
//   full         entry is valid
// ----------------------------------------------------------------------------
module instr_fetch_skid_buf
  import instr_fetch_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              unload,
  input  logic              flush,
  input  logic [DATA_W-1:0] data_in,
  input  logic [ADDR_W-1:0] pc_in,
  output logic [DATA_W-1:0] data,
  output logic [ADDR_W-1:0] pc,
  output logic              full
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data <= '0;
      pc   <= '0;
      full <= 1'b0;
    end else if (flush) begin
      full <= 1'b0;
    end else if (load) begin
      data <= data_in;
      pc   <= pc_in;
      full <= 1'b1;
    end else if (unload) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// ----------------------------------------------------------------------------
// instr_fetch
//   Fetch stage feeding control_unit. Owns the program counter, reads one
//   instruction at a time from instruction memory over a req/ack handshake
//   and presents it on a valid/ready interface. A redirect (set_pc) from
//   control_unit reloads the PC and discards everything already fetched.
//
//   state | meaning
//   IDLE  | out of reset, first request issued on the next edge
//   FETCH | request outstanding at imem_addr, responses go to the output slot
//   WAIT  | response parked in the skid buffer, waiting for the slot to free
//   DRAIN | stale request outstanding after a redirect, its data is dropped
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   set_pc          redirect request (jump taken), highest priority
//   pc_target       redirect address, sampled while set_pc=1
//   imem_req        read request, held until imem_ack
//   imem_addr       read address, stable while imem_req=1
//   imem_ack        read complete, imem_data valid this cycle
//   imem_data       instruction word from memory
//   instr           instruction presented to control_unit
//   instr_pc        address of the presented instruction
//   instr_valid     instr/instr_pc valid
//   instr_ready     control_unit consumes on an edge with valid&ready
// ----------------------------------------------------------------------------
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                DATA_W   = DATA_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_pc,
  input  logic [ADDR_W-1:0] pc_target,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_data,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready
);

  fetch_state_e      state;
  fetch_state_e      state_nxt;

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_nxt;
  logic [ADDR_W-1:0] pc_inc;

  logic              imem_req_nxt;
  logic [ADDR_W-1:0] imem_addr_nxt;
  logic [DATA_W-1:0] instr_nxt;
  logic [ADDR_W-1:0] instr_pc_nxt;
  logic              instr_valid_nxt;

  logic              slot_free;

  logic              skid_load;
  logic              skid_unload;
  logic              skid_flush;
  logic [DATA_W-1:0] skid_data;
  logic [ADDR_W-1:0] skid_pc;
  logic              skid_full;

  // Output slot can accept new data if empty or being consumed this edge.
  assign slot_free = !instr_valid || instr_ready;

  // Wraps modulo 2^ADDR_W.
  assign pc_inc = pc + ADDR_W'(1);

  instr_fetch_skid_buf #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .load    (skid_load),
    .unload  (skid_unload),
    .flush   (skid_flush),
    .data_in (imem_data),
    .pc_in   (pc),
    .data    (skid_data),
    .pc      (skid_pc),
    .full    (skid_full)
  );

  // --------------------------------------------------------------------------
  // State and registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      pc          <= RESET_PC;
      imem_req    <= 1'b0;
      imem_addr   <= '0;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      imem_req    <= imem_req_nxt;
      imem_addr   <= imem_addr_nxt;
      instr       <= instr_nxt;
      instr_pc    <= instr_pc_nxt;
      instr_valid <= instr_valid_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        if (set_pc) begin
          // An unacked request must be drained before fetching the target.
          state_nxt = imem_ack ? ST_FETCH : ST_DRAIN;
        end else if (imem_ack && !slot_free) begin
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (set_pc || (instr_ready && skid_full)) begin
          state_nxt = ST_FETCH;
        end
      end
      ST_DRAIN: begin
        if (imem_ack) begin
          state_nxt = ST_FETCH;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath / output next values
  // --------------------------------------------------------------------------
  always_comb begin
    pc_nxt          = pc;
    imem_req_nxt    = imem_req;
    imem_addr_nxt   = imem_addr;
    instr_nxt       = instr;
    instr_pc_nxt    = instr_pc;
    instr_valid_nxt = instr_valid;
    skid_load       = 1'b0;
    skid_unload     = 1'b0;
    skid_flush      = 1'b0;

    // Redirect: common part for every state.
    if (set_pc) begin
      pc_nxt          = pc_target;
      instr_valid_nxt = 1'b0;
      skid_flush      = 1'b1;
    end

    case (state)
      ST_IDLE: begin
        imem_req_nxt  = 1'b1;
        imem_addr_nxt = set_pc ? pc_target : pc;
      end

      ST_FETCH: begin
        if (set_pc) begin
          // Without an ack the request stays up unchanged and is drained.
          if (imem_ack) begin
            imem_addr_nxt = pc_target;
          end
        end else if (imem_ack) begin
          pc_nxt = pc_inc;
          if (slot_free) begin
            instr_nxt       = imem_data;
            instr_pc_nxt    = pc;
            instr_valid_nxt = 1'b1;
            imem_addr_nxt   = pc_inc;
          end else begin
            skid_load    = 1'b1;
            imem_req_nxt = 1'b0;
          end
        end else if (instr_valid && instr_ready) begin
          instr_valid_nxt = 1'b0;
        end
      end

      ST_WAIT: begin
        if (set_pc) begin
          imem_req_nxt  = 1'b1;
          imem_addr_nxt = pc_target;
        end else if (instr_ready && skid_full) begin
          instr_nxt       = skid_data;
          instr_pc_nxt    = skid_pc;
          instr_valid_nxt = 1'b1;
          skid_unload     = 1'b1;
          imem_req_nxt    = 1'b1;
          imem_addr_nxt   = pc;
        end
      end

      ST_DRAIN: begin
        // Returned data is discarded; restart at the latest PC.
        if (imem_ack) begin
          imem_addr_nxt = set_pc ? pc_target : pc;
        end
      end

      default: begin
        imem_req_nxt    = 1'b0;
        instr_valid_nxt = 1'b0;
      end
    endcase
  end

endmodule
